// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, mux codes, trap causes
// and the control-word layout driven onto the datapath.
package ctrl_pkg;

  localparam logic [3:0] StIf      = 4'd0;
  localparam logic [3:0] StRf      = 4'd1;
  localparam logic [3:0] StImm2    = 4'd2;
  localparam logic [3:0] StAluR3   = 4'd3;
  localparam logic [3:0] StAluRi3  = 4'd4;
  localparam logic [3:0] StAlu4    = 4'd5;
  localparam logic [3:0] StBranch3 = 4'd6;
  localparam logic [3:0] StMemRef3 = 4'd7;
  localparam logic [3:0] StLoad4   = 4'd8;
  localparam logic [3:0] StStore4  = 4'd9;
  localparam logic [3:0] StLoad5   = 4'd10;
  localparam logic [3:0] StJump3   = 4'd11;
  localparam logic [3:0] StTrap    = 4'd12;

  localparam int unsigned OpAdd  = 'h00;
  localparam int unsigned OpJump = 'h02;
  localparam int unsigned OpBeq  = 'h04;
  localparam int unsigned OpAddi = 'h08;
  localparam int unsigned OpLdi  = 'h0F;
  localparam int unsigned OpLd   = 'h23;
  localparam int unsigned OpStr  = 'h2B;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluImm   = 2'b11;

  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBBranch = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  localparam logic [1:0] M2rAlu = 2'b00;
  localparam logic [1:0] M2rMem = 2'b01;
  localparam logic [1:0] M2rImm = 2'b10;

  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseIllegal = 2'd1;
  localparam logic [1:0] CauseTimeout = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_dst;
    logic       alu_src_a;
    logic       imm_inject;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [1:0] mem_to_reg;
  } ctrl_word_t;

  // Wait counter must hold values up to the timeout itself; a disabled watchdog still needs 1 bit.
  function automatic int unsigned wait_cnt_w(int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/control_word_decode.sv
// Combinational per-state control word; IF is the only state whose word depends on mem_ready.
module control_word_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6
) (
  input  logic [3:0]          state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output ctrl_word_t          cw
);

  always_comb begin
    cw = '0;
    case (state)
      StIf: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SrcBFour;
        cw.alu_op    = AluAdd;
        cw.pc_source = PcAlu;
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      StRf: begin
        cw.alu_src_b = SrcBBranch;
        cw.alu_op    = AluAdd;
      end
      StImm2: begin
        cw.imm_inject = 1'b1;
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = M2rImm;
      end
      StAluR3: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SrcBReg;
        cw.alu_op    = AluFunct;
      end
      StAluRi3: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SrcBImm;
        cw.alu_op    = AluImm;
      end
      StAlu4: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = M2rAlu;
        cw.reg_dst    = (opcode == OPCODE_W'(OpAdd));
      end
      StBranch3: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = SrcBReg;
        cw.alu_op        = AluSub;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PcAluOut;
      end
      StMemRef3: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SrcBImm;
        cw.alu_op    = AluAdd;
      end
      StLoad4: begin
        cw.mem_read = 1'b1;
        cw.i_or_d   = 1'b1;
      end
      StStore4: begin
        cw.mem_write = 1'b1;
        cw.i_or_d    = 1'b1;
      end
      StLoad5: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = M2rMem;
      end
      StJump3: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PcJump;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control: state register, next-state logic, memory watchdog, stall gating
// and retired-instruction accounting around the combinational control-word decoder.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W     = 6,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_W-1:0]     opcode,
  input  logic                    mem_ready,
  input  logic                    stall,
  output logic [3:0]              state,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    ir_write,
  output logic                    reg_write,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    i_or_d,
  output logic                    reg_dst,
  output logic                    alu_src_a,
  output logic                    imm_inject,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_source,
  output logic [1:0]              mem_to_reg,
  output logic                    trap,
  output logic [1:0]              trap_cause,
  output logic                    retire,
  output logic [RETIRE_CNT_W-1:0] retire_count
);

  localparam int unsigned CntW = wait_cnt_w(MEM_TIMEOUT);

  logic [3:0]              state_q, state_d, nxt;
  logic [CntW-1:0]         wait_q, wait_d;
  logic [1:0]              cause_q, cause_d, nxt_cause;
  logic                    retire_q, retire_d;
  logic [RETIRE_CNT_W-1:0] count_q, count_d;
  logic                    mem_wait, timeout, hold, ends_instr;
  ctrl_word_t              cw;

  always_comb begin
    nxt       = state_q;
    nxt_cause = cause_q;
    mem_wait  = 1'b0;
    case (state_q)
      StIf:     if (mem_ready) nxt = StRf; else mem_wait = 1'b1;
      StRf: begin
        if      (opcode == OPCODE_W'(OpLdi))  nxt = StImm2;
        else if (opcode == OPCODE_W'(OpAdd))  nxt = StAluR3;
        else if (opcode == OPCODE_W'(OpAddi)) nxt = StAluRi3;
        else if (opcode == OPCODE_W'(OpBeq))  nxt = StBranch3;
        else if (opcode == OPCODE_W'(OpLd) || opcode == OPCODE_W'(OpStr)) nxt = StMemRef3;
        else if (opcode == OPCODE_W'(OpJump)) nxt = StJump3;
        else begin
          nxt       = StTrap;
          nxt_cause = CauseIllegal;
        end
      end
      StAluR3, StAluRi3: nxt = StAlu4;
      StMemRef3: nxt = (opcode == OPCODE_W'(OpLd)) ? StLoad4 : StStore4;
      StLoad4:   if (mem_ready) nxt = StLoad5; else mem_wait = 1'b1;
      StStore4:  if (mem_ready) nxt = StIf;    else mem_wait = 1'b1;
      StImm2, StAlu4, StBranch3, StLoad5, StJump3: nxt = StIf;
      StTrap:    nxt = StTrap;
      default:   nxt = StTrap;
    endcase

    timeout = (MEM_TIMEOUT != 0) && mem_wait && (wait_q == CntW'(MEM_TIMEOUT));
    if (timeout) begin
      nxt       = StTrap;
      nxt_cause = CauseTimeout;
    end
  end

  // Only these states complete an instruction; trap entry never counts as a retire.
  assign ends_instr = (state_q == StImm2) || (state_q == StAlu4) || (state_q == StBranch3) ||
                      (state_q == StLoad5) || (state_q == StJump3) || (state_q == StStore4);

  always_comb begin
    state_d  = stall ? state_q : nxt;
    cause_d  = stall ? cause_q : nxt_cause;
    retire_d = !stall && (nxt == StIf) && ends_instr;
    count_d  = count_q + RETIRE_CNT_W'(retire_d);
    if (stall)               wait_d = wait_q;
    else if (nxt != state_q) wait_d = '0;
    else if (mem_wait)       wait_d = wait_q + CntW'(1);
    else                     wait_d = wait_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIf;
      wait_q   <= '0;
      cause_q  <= CauseNone;
      retire_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cause_q  <= cause_d;
      retire_q <= retire_d;
      count_q  <= count_d;
    end
  end

  control_word_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .state    (state_q),
    .opcode   (opcode),
    .mem_ready(mem_ready),
    .cw       (cw)
  );

  // Write enables are suppressed during reset and stall; read-side controls pass through.
  assign hold          = stall | ~rst_n;
  assign pc_write      = cw.pc_write & ~hold;
  assign pc_write_cond = cw.pc_write_cond & ~hold;
  assign ir_write      = cw.ir_write & ~hold;
  assign reg_write     = cw.reg_write & ~hold;
  assign mem_write     = cw.mem_write & ~hold;
  assign mem_read      = cw.mem_read;
  assign i_or_d        = cw.i_or_d;
  assign reg_dst       = cw.reg_dst;
  assign alu_src_a     = cw.alu_src_a;
  assign imm_inject    = cw.imm_inject;
  assign alu_src_b     = cw.alu_src_b;
  assign alu_op        = cw.alu_op;
  assign pc_source     = cw.pc_source;
  assign mem_to_reg    = cw.mem_to_reg;

  assign state        = state_q;
  assign trap         = (state_q == StTrap);
  assign trap_cause   = cause_q;
  assign retire       = retire_q;
  assign retire_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: directed scenarios plus a randomized instruction stream checked
// against an instruction-path reference model.
module tb_multicycle_control_fsm;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_JUMP = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LDI  = 6'h0F;
  localparam logic [5:0] OP_LD   = 6'h23;
  localparam logic [5:0] OP_STR  = 6'h2B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] state;
  logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
  logic       i_or_d, reg_dst, alu_src_a, imm_inject;
  logic [1:0] alu_src_b, alu_op, pc_source, mem_to_reg;
  logic       trap, retire;
  logic [1:0] trap_cause;
  logic [3:0] retire_count;
  logic [17:0] cw_act;
  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(
    .OPCODE_W(6), .MEM_TIMEOUT(4), .RETIRE_CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
    .state(state), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .imm_inject(imm_inject), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .mem_to_reg(mem_to_reg), .trap(trap),
    .trap_cause(trap_cause), .retire(retire), .retire_count(retire_count)
  );

  assign cw_act = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, i_or_d,
                   reg_dst, alu_src_a, imm_inject, alu_src_b, alu_op, pc_source, mem_to_reg};

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Control word table straight from the state descriptions.
  function automatic logic [17:0] exp_cw(int s, logic [5:0] op, logic mr, logic st);
    logic pw, pwc, irw, rw, mrd, mw, iod, rd, asa, imm;
    logic [1:0] asb, aop, ps, m2r;
    {pw, pwc, irw, rw, mrd, mw, iod, rd, asa, imm} = '0;
    {asb, aop, ps, m2r} = '0;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; pw = mr; irw = mr; end
      1:  asb = 2'b11;
      2:  begin imm = 1; rw = 1; m2r = 2'b10; end
      3:  begin asa = 1; aop = 2'b10; end
      4:  begin asa = 1; asb = 2'b10; aop = 2'b11; end
      5:  begin rw = 1; rd = (op == OP_ADD); end
      6:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      7:  begin asa = 1; asb = 2'b10; end
      8:  begin mrd = 1; iod = 1; end
      9:  begin mw = 1; iod = 1; end
      10: begin rw = 1; m2r = 2'b01; end
      11: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    if (st) begin pw = 0; pwc = 0; irw = 0; rw = 0; mw = 0; end
    return {pw, pwc, irw, rw, mrd, mw, iod, rd, asa, imm, asb, aop, ps, m2r};
  endfunction

  function automatic int path_len(logic [5:0] op);
    case (op)
      OP_ADD, OP_ADDI, OP_STR: return 4;
      OP_LD:                   return 5;
      default:                 return 3;
    endcase
  endfunction

  function automatic int path_state(logic [5:0] op, int i);
    if (i == 0) return 0;
    if (i == 1) return 1;
    case (op)
      OP_ADD:  return (i == 2) ? 3 : 5;
      OP_ADDI: return (i == 2) ? 4 : 5;
      OP_LDI:  return 2;
      OP_BEQ:  return 6;
      OP_JUMP: return 11;
      OP_LD:   return (i == 2) ? 7 : (i == 3) ? 8 : 10;
      default: return (i == 2) ? 7 : 9;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; mem_ready = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; stall = 1'b0; opcode = OP_ADD;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (retire !== 1'b0 || retire_count !== 4'd0 || trap_cause !== 2'd0) begin
      errors++; $display("FAIL reset_regs got retire=%b count=%0d cause=%0d want 0 0 0", retire, retire_count, trap_cause); end
    checks++; if ({pc_write, pc_write_cond, ir_write, reg_write, mem_write} !== 5'b0) begin
      errors++; $display("FAIL reset_enables got %b want 00000", {pc_write, pc_write_cond, ir_write, reg_write, mem_write}); end
    @(posedge clk); #1; rst_n = 1'b1; #1;
    checks++; if (cw_act !== exp_cw(0, opcode, 1'b1, 1'b0)) begin
      errors++; $display("FAIL post_reset_cw got %h want %h", cw_act, exp_cw(0, opcode, 1'b1, 1'b0)); end
  endtask

  task automatic test_add();
    int seq[4] = '{0, 1, 3, 5};
    apply_reset(); opcode = OP_ADD; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state !== 4'(seq[i])) begin errors++; $display("FAIL add_state[%0d] got %0d want %0d", i, state, seq[i]); end
      checks++; if (cw_act !== exp_cw(seq[i], opcode, 1'b1, 1'b0)) begin
        errors++; $display("FAIL add_cw[%0d] got %h want %h", i, cw_act, exp_cw(seq[i], opcode, 1'b1, 1'b0)); end
      checks++; if (retire !== 1'b0) begin errors++; $display("FAIL add_early_retire[%0d] got %b want 0", i, retire); end
      step();
    end
    #1;
    checks++; if (state !== 4'd0 || retire !== 1'b1 || retire_count !== 4'd1) begin
      errors++; $display("FAIL add_retire got state=%0d retire=%b count=%0d want 0 1 1", state, retire, retire_count); end
    step(); #1;
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL add_retire_pulse got %b want 0", retire); end
  endtask

  task automatic test_load_wait();
    int st[8] = '{0, 1, 7, 8, 8, 8, 8, 10};
    logic mr[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset(); opcode = OP_LD;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i]; #1;
      checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL ld_state[%0d] got %0d want %0d", i, state, st[i]); end
      checks++; if (cw_act !== exp_cw(st[i], opcode, mr[i], 1'b0)) begin
        errors++; $display("FAIL ld_cw[%0d] got %h want %h", i, cw_act, exp_cw(st[i], opcode, mr[i], 1'b0)); end
      step();
    end
    #1;
    checks++; if (state !== 4'd0 || retire !== 1'b1 || retire_count !== 4'd1) begin
      errors++; $display("FAIL ld_retire got state=%0d retire=%b count=%0d want 0 1 1", state, retire, retire_count); end
  endtask

  task automatic test_timeout();
    apply_reset(); opcode = OP_ADD; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL to_wait_state[%0d] got %0d want 0", i, state); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (state !== 4'd12 || trap !== 1'b1 || trap_cause !== 2'd2) begin
        errors++; $display("FAIL to_trap[%0d] got state=%0d trap=%b cause=%0d want 12 1 2", i, state, trap, trap_cause); end
      checks++; if (cw_act !== 18'h0) begin errors++; $display("FAIL to_trap_cw[%0d] got %h want 0", i, cw_act); end
      mem_ready = 1'b1;
      step();
    end
    rst_n = 1'b0; #1;
    checks++; if (state !== 4'd0 || trap_cause !== 2'd0 || trap !== 1'b0) begin
      errors++; $display("FAIL to_async_reset got state=%0d cause=%0d want 0 0", state, trap_cause); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_illegal();
    int st[4] = '{0, 1, 12, 12};
    apply_reset(); opcode = 6'h3F; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state !== 4'(st[i]) || retire !== 1'b0) begin
        errors++; $display("FAIL ill_state[%0d] got state=%0d retire=%b want %0d 0", i, state, retire, st[i]); end
      step();
    end
    #1;
    checks++; if (trap_cause !== 2'd1 || retire_count !== 4'd0) begin
      errors++; $display("FAIL ill_cause got cause=%0d count=%0d want 1 0", trap_cause, retire_count); end
  endtask

  task automatic test_stall_alu4();
    int st[7] = '{0, 1, 4, 5, 5, 5, 0};
    logic sl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int rets;
    rets = 0;
    apply_reset(); opcode = OP_ADDI; mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      stall = sl[i]; #1;
      checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL stl_state[%0d] got %0d want %0d", i, state, st[i]); end
      checks++; if (cw_act !== exp_cw(st[i], opcode, 1'b1, sl[i])) begin
        errors++; $display("FAIL stl_cw[%0d] got %h want %h", i, cw_act, exp_cw(st[i], opcode, 1'b1, sl[i])); end
      if (retire === 1'b1) rets++;
      step();
    end
    stall = 1'b0; #1;
    if (retire === 1'b1) rets++;
    checks++; if (rets !== 1 || retire_count !== 4'd1) begin
      errors++; $display("FAIL stl_retire got pulses=%0d count=%0d want 1 1", rets, retire_count); end
  endtask

  task automatic test_jump_wrap();
    int exp_cnt;
    exp_cnt = 0;
    apply_reset(); opcode = OP_JUMP; mem_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      #1;
      checks++; if (state !== 4'd0 || retire_count !== 4'(exp_cnt)) begin
        errors++; $display("FAIL jmp_if[%0d] got state=%0d count=%0d want 0 %0d", n, state, retire_count, exp_cnt); end
      step(); step(); #1;
      checks++; if (state !== 4'd11 || pc_write !== 1'b1 || pc_source !== 2'b10) begin
        errors++; $display("FAIL jmp_j3[%0d] got state=%0d pw=%b ps=%b want 11 1 10", n, state, pc_write, pc_source); end
      exp_cnt = (exp_cnt + 1) % 16;
      step();
    end
    #1;
    checks++; if (retire_count !== 4'(exp_cnt) || retire !== 1'b1) begin
      errors++; $display("FAIL jmp_wrap got count=%0d retire=%b want %0d 1", retire_count, retire, exp_cnt); end
  endtask

  task automatic test_random();
    logic [5:0] ops[7] = '{OP_ADD, OP_JUMP, OP_BEQ, OP_ADDI, OP_LDI, OP_LD, OP_STR};
    logic [5:0] op;
    int idx, waits, exp_cnt, s;
    logic exp_ret;
    apply_reset();
    idx = 0; waits = 0; exp_cnt = 0; exp_ret = 1'b0;
    op = ops[$urandom_range(0, 6)];
    opcode = op;
    for (int cyc = 0; cyc < 400; cyc++) begin
      s = path_state(op, idx);
      stall = ($urandom_range(0, 3) == 0);
      mem_ready = (waits >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      checks++; if (state !== 4'(s)) begin errors++; $display("FAIL rnd_state[%0d] got %0d want %0d", cyc, state, s); end
      checks++; if (cw_act !== exp_cw(s, op, mem_ready, stall)) begin
        errors++; $display("FAIL rnd_cw[%0d] got %h want %h", cyc, cw_act, exp_cw(s, op, mem_ready, stall)); end
      checks++; if (retire !== exp_ret || retire_count !== 4'(exp_cnt)) begin
        errors++; $display("FAIL rnd_retire[%0d] got %b/%0d want %b/%0d", cyc, retire, retire_count, exp_ret, exp_cnt); end
      exp_ret = 1'b0;
      if (!stall) begin
        if ((s == 0 || s == 8 || s == 9) && !mem_ready) begin
          waits++;
        end else begin
          waits = 0;
          idx++;
          if (idx == path_len(op)) begin
            idx = 0;
            exp_ret = 1'b1;
            exp_cnt = (exp_cnt + 1) % 16;
            op = ops[$urandom_range(0, 6)];
          end
        end
      end
      step();
      opcode = op;
    end
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_timeout();
    test_illegal();
    test_stall_alu4();
    test_jump_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised successor to the combinational control decoder of the multicycle CPU: owns the control state register and the next-state logic as well as the per-state control word.
- Adds a variable-latency memory handshake (mem_ready), a pipeline-wide stall, a bus-timeout watchdog, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register's opcode field and the datapath muxes/enables.

Parameters:
- OPCODE_W, 6: opcode field width.
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready; 0 disables the watchdog.
- RETIRE_CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  IR opcode field; sampled in REGISTER_FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- stall  in  1  freeze request from outside.
- state  out  4  current state encoding.
- pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write  out  1 each  datapath enables.
- i_or_d, reg_dst, alu_src_a, imm_inject  out  1 each  mux selects.
- alu_src_b, alu_op, pc_source, mem_to_reg  out  2 each  mux selects and ALU op class.
- trap  out  1  FSM is in TRAP.
- trap_cause  out  2  0 none, 1 illegal opcode, 2 bus timeout.
- retire  out  1  one-cycle pulse when an instruction completes.
- retire_count  out  RETIRE_CNT_W  completed-instruction count; wraps modulo 2^RETIRE_CNT_W.

Behaviour:
- State encodings:
  - IF=0, RF=1, IMM2=2, ALU_R3=3, ALU_RI3=4, ALU4=5, BRANCH3=6, MEM_REF3=7
  - LOAD4=8, STORE4=9, LOAD5=10, JUMP3=11, TRAP=12
- Opcodes: ADD=6'h00, JUMP=6'h02, BEQ=6'h04, ADDI=6'h08, LDI=6'h0F, LD=6'h23, STR=6'h2B.
- Reset (async, rst_n low):
  - state=IF, trap_cause=0, retire=0, retire_count=0, wait counter=0.
  - All write enables (pc_write, pc_write_cond, ir_write, reg_write, mem_write) are forced 0 while rst_n=0.
- Transitions:
  - IF→RF on mem_ready.
  - RF→ by opcode: LDI→IMM2; ADD→ALU_R3; ADDI→ALU_RI3; BEQ→BRANCH3; LD/STR→MEM_REF3; JUMP→JUMP3; any other→TRAP with cause 1.
  - ALU_R3 and ALU_RI3→ALU4.
  - MEM_REF3→LOAD4 (LD) or STORE4 (STR).
  - LOAD4→LOAD5 on mem_ready.
  - STORE4→IF on mem_ready.
  - IMM2, ALU4, BRANCH3, LOAD5, JUMP3→IF.
  - TRAP is sticky until reset.
- Memory wait:
  - In IF/LOAD4/STORE4 with mem_ready=0, the state holds and the wait counter increments.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT while mem_ready=0, next state is TRAP with cause 2.
  - The counter clears on any state change.
- Control word (Moore on state, with IF the exception):
  - IF: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write are asserted only in the mem_ready cycle.
  - RF: alu_src_a=0, alu_src_b=11, alu_op=00.
  - IMM2: imm_inject=1, reg_write=1, reg_dst=0, mem_to_reg=10.
  - ALU_R3: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALU_RI3: alu_src_a=1, alu_src_b=10, alu_op=11.
  - ALU4: reg_write=1, mem_to_reg=00; reg_dst=1 for ADD, 0 for ADDI (opcode is held stable by the IR).
  - BRANCH3: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - MEM_REF3: alu_src_a=1, alu_src_b=10, alu_op=00.
  - LOAD4: mem_read=1, i_or_d=1.
  - STORE4: mem_write=1, i_or_d=1.
  - LOAD5: reg_write=1, reg_dst=0, mem_to_reg=01.
  - JUMP3: pc_write=1, pc_source=10.
  - TRAP: all enables 0.
- Stall:
  - While stall=1, state and wait counter hold; pc_write, pc_write_cond, ir_write, reg_write, mem_write are forced 0; mem_read keeps its state value.
  - Stall overrides mem_ready in the same cycle; the access is re-qualified when stall drops.
- Retire:
  - retire=1 for exactly one cycle on the edge entering IF from IMM2/ALU4/BRANCH3/LOAD5/JUMP3/STORE4. It is registered, so it is visible in the first IF cycle.
  - retire_count increments on that same edge.
  - No retire on entry to TRAP.
- Simultaneous events: reset dominates everything; trap entry dominates retire; stall dominates timeout (counter frozen).

Decomposition:
- Package ctrl_pkg: state encodings, opcode constants, alu_op classes, trap_cause codes, MEM_TIMEOUT-derived counter width ($clog2(MEM_TIMEOUT+1), min 1).
- Sub-module control_word_decode: purely combinational (state, opcode, mem_ready) → control word. The top adds the state register, wait counter, stall gating and retire logic.

Test Plan:
- Reset then ADD with mem_ready=1: states 0→1→3→5→0; reg_write=1 and reg_dst=1 in state 5; retire pulses once; retire_count=1.
- LD with mem_ready low for 3 cycles in LOAD4: state stays 8 for 4 cycles; then 10 with mem_to_reg=01, reg_write=1; retire_count increments by 1.
- MEM_TIMEOUT=4 and mem_ready held 0 in IF: TRAP (12) after the 5th wait cycle; trap_cause=2; all enables 0; trap persists until rst_n pulse, then state=0.
- opcode=6'h3F in RF: next state 12, trap_cause=1, retire stays 0.
- stall=1 for 2 cycles during ALU4 (ADDI): state held at 5; reg_write=0 while stalled; reg_write=1 with reg_dst=0 on the first unstalled cycle; exactly one retire.
- RETIRE_CNT_W=4, 16 JUMP instructions: retire_count wraps 15→0; pc_write=1 with pc_source=10 in each state 11.
